// File: rtl/fifo_stream_rd.sv
// Read-side adapter: drains a non-showahead FIFO into a valid/ready stream via a 3-entry prefetch.
// Optional feature: define FIFO_STREAM_RD_COUNT_EN to add the out_count accepted-beat counter.
module fifo_stream_rd #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_q,
    output logic                   fifo_rdreq,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef FIFO_STREAM_RD_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] out_count
`endif
);

    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic                  inflight_q;
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] entry_q [3];
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Buffered plus in-flight words never exceed the three slots, so capture cannot overflow.
    assign fifo_rdreq = reset_n && !fifo_empty &&
                        (({1'b0, buf_cnt_q} + {2'b00, inflight_q}) < 3'd3);
    assign out_valid  = (buf_cnt_q != 2'd0);
    assign pop        = out_valid && out_ready;

    always_comb begin
        out_data = entry_q[0];
        case (rd_ptr_q)
            2'd1:    out_data = entry_q[1];
            2'd2:    out_data = entry_q[2];
            default: out_data = entry_q[0];
        endcase
    end

    always_comb begin
        buf_cnt_d = buf_cnt_q;
        unique case ({inflight_q, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
            2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_cnt_q  <= 2'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            // Data requested last cycle is on fifo_q now.
            if (inflight_q) begin
                entry_q[wr_ptr_q] <= fifo_q;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            buf_cnt_q  <= buf_cnt_d;
            inflight_q <= fifo_rdreq;
        end
    end

`ifdef FIFO_STREAM_RD_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

    assign out_count = count_q;
`else
    // Keeps COUNT_WIDTH referenced when the counter is compiled out.
    logic [COUNT_WIDTH-1:0] unused_count;
    assign unused_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Scoreboard bench for fifo_stream_rd: a queue-based FIFO model feeds the DUT, and every
// accepted beat is compared against the words pushed into that model.
module tb_fifo_stream_rd;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_q;
    logic          fifo_rdreq;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
`ifdef FIFO_STREAM_RD_COUNT_EN
    logic [CW-1:0] out_count;
`endif

    always #5 clock = ~clock;

    fifo_stream_rd #(
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rdreq (fifo_rdreq),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef FIFO_STREAM_RD_COUNT_EN
        ,
        .out_count  (out_count)
`endif
    );

    logic [DW-1:0] fifo_mem [$];
    logic [DW-1:0] sb [$];
    logic          hold_empty;
    logic          rd_s;
    int            n_checks;
    int            n_errors;
    int            n_pops;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic update_empty();
        fifo_empty = hold_empty || (fifo_mem.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_mem.push_back(w);
        sb.push_back(w);
        update_empty();
    endtask

    // One clock: monitor at negedge, FIFO model responds just after posedge.
    task automatic step();
        logic [DW-1:0] exp_w;
        @(negedge clock);
        rd_s = fifo_rdreq;
        if (fifo_rdreq) check("rdreq_while_empty", fifo_empty, 1'b0);
        if (reset_n && out_valid && out_ready) begin
            check("sb_has_word", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("order", out_data, exp_w);
            end
            n_pops++;
        end
        @(posedge clock);
        #1;
        if (rd_s && fifo_mem.size() != 0) fifo_q = fifo_mem.pop_front();
        update_empty();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        fifo_mem.delete();
        sb.delete();
        n_pops = 0;
        update_empty();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0]    lat_rd;
        logic [5:0]    lat_vld;
        logic [DW-1:0] lat_words [3];
        int            pushed;
        int            cyc;
        int            pulses;

        lat_rd       = 6'b000111;
        lat_vld      = 6'b011100;
        lat_words[0] = 32'h11;
        lat_words[1] = 32'h22;
        lat_words[2] = 32'h33;
        n_checks     = 0;
        n_errors     = 0;
        n_pops       = 0;
        hold_empty   = 1'b0;
        out_ready    = 1'b0;
        fifo_q       = '0;
        rd_s         = 1'b0;
        do_reset();

        // Reset held with data waiting upstream
        push(32'h11);
        push(32'h22);
        push(32'h33);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_rdreq", fifo_rdreq, 1'b0);
            check("rst_valid", out_valid, 1'b0);
            check("rst_data", out_data, '0);
        end
`ifdef FIFO_STREAM_RD_COUNT_EN
        check("rst_count", out_count, '0);
`endif

        // Latency with preloaded FIFO
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("lat_rdreq", fifo_rdreq, lat_rd[i]);
            check("lat_valid", out_valid, lat_vld[i]);
            if (i >= 2 && i <= 4) check("lat_data", out_data, lat_words[i-2]);
            step();
        end
        check("lat_drained", sb.size(), 0);

        // Backpressure: prefetch fills, then drains with no bubble
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h300 + 32'(i));
        #1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (fifo_rdreq) pulses++;
            step();
        end
        check("bp_pulses", pulses, 3);
        check("bp_rdreq_idle", fifo_rdreq, 1'b0);
        check("bp_valid", out_valid, 1'b1);
        check("bp_head", out_data, 32'h300);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("bp_nogap", out_valid, 1'b1);
            step();
        end
        check("bp_drained", sb.size(), 0);

        // Random stalls on both sides
        pushed = 0;
        cyc    = 0;
        while ((pushed < 1000 || sb.size() != 0) && cyc < 20000) begin
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                push($urandom);
                pushed++;
            end
            hold_empty = ($urandom_range(0, 7) == 0);
            update_empty();
            out_ready = $urandom_range(0, 1) != 0;
            step();
            cyc++;
        end
        check("rand_drained", sb.size(), 0);
        check("rand_pushed", pushed, 1000);
        hold_empty = 1'b0;
        out_ready  = 1'b1;
        update_empty();
        step();

        // Reset with two words buffered and one in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h501 + 32'(i));
        #1;
        step();
        step();
        step();
        check("mr_pre_valid", out_valid, 1'b1);
        check("mr_pre_head", out_data, 32'h501);
        do_reset();
        #1;
        check("mr_valid", out_valid, 1'b0);
        check("mr_data", out_data, '0);
        check("mr_rdreq", fifo_rdreq, 1'b0);
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        push(32'hA1);
        push(32'hA2);
        drain("mr_drained", 20);
        step();
        step();
        check("mr_pops", n_pops, 2);
        check("mr_idle_valid", out_valid, 1'b0);

`ifdef FIFO_STREAM_RD_COUNT_EN
        // Beat counter wraps modulo 2**CW
        do_reset();
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        pushed    = 0;
        cyc       = 0;
        while ((pushed < 70000 || sb.size() != 0) && cyc < 80000) begin
            if (pushed < 70000 && fifo_mem.size() < 2) begin
                push(32'(pushed));
                pushed++;
            end
            step();
            cyc++;
        end
        check("cnt_drained", sb.size(), 0);
        check("cnt_pops", n_pops, 70000);
        check("cnt_wrap", out_count, 16'd4464);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
